// File: rtl/bip_control_unit.sv
// BIP I instruction-sequencing control unit: PC, IR and a fetch/decode/execute/halt FSM.
// Optional 16-bit saturating cycle counter enabled by defining BIP_CU_CYCLE_COUNT_EN.
module bip_control_unit #(
    parameter int unsigned OPCODE_LENGTH   = 5,
    parameter int unsigned OPERANDO_LENGTH = 11,
    parameter int unsigned PC_LENGTH       = 11,
    parameter int unsigned INSTR_LENGTH    = 16
) (
    input  logic                       i_clock,
    input  logic                       i_reset,
    input  logic                       i_enable,
    input  logic [INSTR_LENGTH-1:0]    i_instr,
    output logic [PC_LENGTH-1:0]       o_pc_addr,
    output logic                       o_rd_prog,
    output logic [1:0]                 o_selA,
    output logic                       o_selB,
    output logic                       o_wrACC,
    output logic [OPCODE_LENGTH-1:0]   o_opcode,
    output logic [OPERANDO_LENGTH-1:0] o_operando,
    output logic                       o_wrRAM,
    output logic                       o_rdRAM,
    output logic                       o_halt
`ifdef BIP_CU_CYCLE_COUNT_EN
    ,
    output logic [15:0]                o_cycle_count
`endif
);

    typedef enum logic [1:0] {
        StFetch,
        StDecode,
        StExec,
        StHalt
    } state_e;

    localparam logic [OPCODE_LENGTH-1:0] OpHlt  = OPCODE_LENGTH'(0);
    localparam logic [OPCODE_LENGTH-1:0] OpSto  = OPCODE_LENGTH'(1);
    localparam logic [OPCODE_LENGTH-1:0] OpLd   = OPCODE_LENGTH'(2);
    localparam logic [OPCODE_LENGTH-1:0] OpLdi  = OPCODE_LENGTH'(3);
    localparam logic [OPCODE_LENGTH-1:0] OpAdd  = OPCODE_LENGTH'(4);
    localparam logic [OPCODE_LENGTH-1:0] OpAddi = OPCODE_LENGTH'(5);
    localparam logic [OPCODE_LENGTH-1:0] OpSub  = OPCODE_LENGTH'(6);
    localparam logic [OPCODE_LENGTH-1:0] OpSubi = OPCODE_LENGTH'(7);

    localparam logic [1:0] SelAMem = 2'd0;
    localparam logic [1:0] SelAImm = 2'd1;
    localparam logic [1:0] SelAAlu = 2'd2;

    state_e                  state_q, state_d;
    logic [PC_LENGTH-1:0]    pc_q, pc_d;
    logic [INSTR_LENGTH-1:0] ir_q, ir_d;
    logic [OPCODE_LENGTH-1:0] ir_opcode;

    assign ir_opcode = ir_q[INSTR_LENGTH-1 -: OPCODE_LENGTH];

    // State register
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFetch:  if (i_enable) state_d = StDecode;
            StDecode: state_d = StExec;
            StExec:   state_d = (ir_opcode == OpHlt) ? StHalt : StFetch;
            StHalt:   state_d = StHalt;
            default:  state_d = StFetch;
        endcase
    end

    // PC and IR only move in DECODE; PC wraps naturally at 2^PC_LENGTH.
    always_comb begin
        pc_d = pc_q;
        ir_d = ir_q;
        if (state_q == StDecode) begin
            ir_d = i_instr;
            pc_d = pc_q + PC_LENGTH'(1);
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            pc_q <= '0;
            ir_q <= '0;
        end else begin
            pc_q <= pc_d;
            ir_q <= ir_d;
        end
    end

    // Output logic; only o_rd_prog looks at inputs, the rest derive from registered state.
    always_comb begin
        o_rd_prog = 1'b0;
        o_selA    = SelAMem;
        o_selB    = 1'b0;
        o_wrACC   = 1'b0;
        o_wrRAM   = 1'b0;
        o_rdRAM   = 1'b0;
        o_halt    = 1'b0;
        unique case (state_q)
            StFetch: o_rd_prog = i_enable & ~i_reset;
            StExec: begin
                case (ir_opcode)
                    OpSto: o_wrRAM = 1'b1;
                    OpLd: begin
                        o_selA  = SelAMem;
                        o_wrACC = 1'b1;
                        o_rdRAM = 1'b1;
                    end
                    OpLdi: begin
                        o_selA  = SelAImm;
                        o_wrACC = 1'b1;
                    end
                    OpAdd, OpSub: begin
                        o_selA  = SelAAlu;
                        o_selB  = 1'b0;
                        o_wrACC = 1'b1;
                        o_rdRAM = 1'b1;
                    end
                    OpAddi, OpSubi: begin
                        o_selA  = SelAAlu;
                        o_selB  = 1'b1;
                        o_wrACC = 1'b1;
                    end
                    default: ;
                endcase
            end
            StHalt:   o_halt = 1'b1;
            default:  ;
        endcase
    end

    assign o_pc_addr  = pc_q;
    assign o_opcode   = ir_opcode;
    assign o_operando = ir_q[OPERANDO_LENGTH-1:0];

`ifdef BIP_CU_CYCLE_COUNT_EN
    logic [15:0] cycle_q;

    // Counts every non-HALT clock, stalls included, and saturates.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            cycle_q <= '0;
        end else if ((state_q != StHalt) && (cycle_q != 16'hFFFF)) begin
            cycle_q <= cycle_q + 16'd1;
        end
    end

    assign o_cycle_count = cycle_q;
`endif

endmodule
